// File: rtl/debug_pkg.sv
// Shared types and parameter defaults for the debug trace block.
package debug_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_POSTTRIG = 2'd2,
    ST_DONE     = 2'd3
  } trace_state_e;

  localparam int DEF_AW           = 18;
  localparam int DEF_DEPTH        = 64;
  localparam int DEF_NBRK         = 4;
  localparam int DEF_POST         = 8;
  localparam int DEF_TIMEOUT      = 1000000;
  localparam int DEF_HALT_ON_TRIG = 1;

endpackage

// File: rtl/debug_trace_if.sv
// Bus bundle between the CPU/debugger side and the trace block.
interface debug_trace_if #(
  parameter int AW    = debug_pkg::DEF_AW,
  parameter int DEPTH = debug_pkg::DEF_DEPTH,
  parameter int NBRK  = debug_pkg::DEF_NBRK
);
  localparam int PW = $clog2(DEPTH);

  logic                 clken;
  logic                 loadIR;
  logic                 loadVMA;
  logic [AW-1:0]        pcIN;
  logic                 arm;
  logic [NBRK*AW-1:0]   brkADDR;
  logic [NBRK-1:0]      brkEN;
  logic [PW-1:0]        rdADDR;
  logic [AW-1:0]        rdDATA;
  logic [PW:0]          count;
  logic [1:0]           state;
  logic                 wdSLOW;
  logic                 wdSTUCK;
  logic                 brkHIT;
  logic                 cpuHALTREQ;

  modport master (
    output clken, loadIR, loadVMA, pcIN, arm, brkADDR, brkEN, rdADDR,
    input  rdDATA, count, state, wdSLOW, wdSTUCK, brkHIT, cpuHALTREQ
  );

  modport slave (
    input  clken, loadIR, loadVMA, pcIN, arm, brkADDR, brkEN, rdADDR,
    output rdDATA, count, state, wdSLOW, wdSTUCK, brkHIT, cpuHALTREQ
  );
endinterface

// File: rtl/debug_watchdog.sv
// Watchdog pair: counts enabled cycles since the last IR load and the last
// VMA load, saturating at TIMEOUT, and flags a slow or stuck processor.
module debug_watchdog
  import debug_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clken_i,
  input  logic loadIR_i,
  input  logic loadVMA_i,
  output logic wdSLOW_o,
  output logic wdSTUCK_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] irCnt_q, irCnt_d;
  logic [CW-1:0] vmaCnt_q, vmaCnt_d;

  // Next counter values: each strobe clears only its own counter
  always_comb begin
    irCnt_d  = irCnt_q;
    vmaCnt_d = vmaCnt_q;
    if (clken_i) begin
      if (loadIR_i)               irCnt_d = '0;
      else if (irCnt_q != LIMIT)  irCnt_d = irCnt_q + CW'(1);
      if (loadVMA_i)              vmaCnt_d = '0;
      else if (vmaCnt_q != LIMIT) vmaCnt_d = vmaCnt_q + CW'(1);
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irCnt_q  <= '0;
      vmaCnt_q <= '0;
    end else begin
      irCnt_q  <= irCnt_d;
      vmaCnt_q <= vmaCnt_d;
    end
  end

  assign wdSLOW_o  = (irCnt_q == LIMIT) && (vmaCnt_q < LIMIT);
  assign wdSTUCK_o = (irCnt_q == LIMIT) && (vmaCnt_q == LIMIT);
endmodule

// File: rtl/debug_trace.sv
// PC trace buffer with breakpoint/watchdog trigger, post-trigger capture
// window, freeze and registered readback (index 0 = newest entry).
module debug_trace
  import debug_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int NBRK         = DEF_NBRK,
  parameter int POST         = DEF_POST,
  parameter int TIMEOUT      = DEF_TIMEOUT,
  parameter int HALT_ON_TRIG = DEF_HALT_ON_TRIG
) (
  input logic         clk,
  input logic         rst,
  debug_trace_if.slave bus
);
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam int QW   = (POST > 0) ? $clog2(POST + 1) : 1;
  localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

  trace_state_e    state_q, state_d;
  logic [PW-1:0]   wp_q, wp_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [QW-1:0]   post_q, post_d;
  logic            brkHit_q, brkHit_d;
  logic            stuckPrev_q;
  logic            halt_q;
  logic            rdValid_q;
  logic [AW-1:0]   rdRaw_q;
  logic [AW-1:0]   mem [DEPTH];

  logic            wdSLOW, wdSTUCK;
  logic            brkMatch, capture, stuckRise;
  logic [PW-1:0]   rdIdx;

  debug_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clken_i   (bus.clken),
    .loadIR_i  (bus.loadIR),
    .loadVMA_i (bus.loadVMA),
    .wdSLOW_o  (wdSLOW),
    .wdSTUCK_o (wdSTUCK)
  );

  // Any enabled breakpoint comparator equal to the presented PC
  always_comb begin
    brkMatch = 1'b0;
    for (int i = 0; i < NBRK; i++) begin
      if (bus.brkEN[i] && (bus.brkADDR[i*AW +: AW] == bus.pcIN)) brkMatch = 1'b1;
    end
  end

  // arm takes priority over capture in the same cycle
  assign capture   = bus.clken && bus.loadIR && !bus.arm &&
                     ((state_q == ST_RUN) || (state_q == ST_POSTTRIG));
  assign stuckRise = wdSTUCK && !stuckPrev_q;
  assign rdIdx     = wp_q - PW'(1) - bus.rdADDR;

  // Capture FSM: arm/restart, trigger detection and post-trigger countdown
  always_comb begin
    state_d  = state_q;
    wp_d     = wp_q;
    count_d  = count_q;
    post_d   = post_q;
    brkHit_d = brkHit_q;
    if (bus.clken) begin
      if (bus.arm) begin
        state_d  = ST_RUN;
        wp_d     = '0;
        count_d  = '0;
        brkHit_d = 1'b0;
      end else begin
        if (capture) begin
          wp_d = wp_q + PW'(1);
          if (count_q != FULL) count_d = count_q + CNTW'(1);
        end
        case (state_q)
          ST_RUN: begin
            if ((capture && brkMatch) || stuckRise) begin
              if (capture && brkMatch) brkHit_d = 1'b1;
              if (POST == 0) begin
                state_d = ST_DONE;
              end else begin
                state_d = ST_POSTTRIG;
                post_d  = QW'(POST);
              end
            end
          end
          ST_POSTTRIG: begin
            if (capture) begin
              post_d = post_q - QW'(1);
              if (post_q == QW'(1)) state_d = ST_DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Control/status registers, halt request and readback range flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wp_q        <= '0;
      count_q     <= '0;
      post_q      <= '0;
      brkHit_q    <= 1'b0;
      stuckPrev_q <= 1'b0;
      halt_q      <= 1'b0;
      rdValid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      count_q     <= count_d;
      post_q      <= post_d;
      brkHit_q    <= brkHit_d;
      if (bus.clken) stuckPrev_q <= wdSTUCK;
      halt_q      <= (HALT_ON_TRIG != 0) && (state_q == ST_DONE);
      rdValid_q   <= (CNTW'(bus.rdADDR) < count_q);
    end
  end

  // Trace RAM: one write port, one registered read port (read-first)
  always_ff @(posedge clk) begin
    if (capture) mem[wp_q] <= bus.pcIN;
    rdRaw_q <= mem[rdIdx];
  end

  assign bus.rdDATA     = rdValid_q ? rdRaw_q : '0;
  assign bus.count      = count_q;
  assign bus.state      = state_q;
  assign bus.brkHIT     = brkHit_q;
  assign bus.cpuHALTREQ = halt_q;
  assign bus.wdSLOW     = wdSLOW;
  assign bus.wdSTUCK    = wdSTUCK;
endmodule
